// File: rtl/irq_ctrl.sv
// irq_ctrl -- fixed-priority interrupt controller on the peripheral bus.
//
// Level src_req lines are edge-detected into per-source pending bits. The
// lowest-index pending & enabled source is presented to the CPU through an
// irq / irq_ack / EOI handshake.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   sel/we/re/addr   single-cycle peripheral bus access (rdy = sel)
//   wdata, rdata     write data / combinational read data
//   src_req[NSRC]    level interrupt requests from peripherals
//   irq, irq_vec     request to CPU and index being presented / serviced
//   irq_ack          one-cycle CPU accept pulse
//
// Register map
//   0 ENABLE  RW  bits[NSRC-1:0]
//   1 PENDING R,  write-1-to-clear
//   2 STATUS  R   {8'b0, irq_vec (6b), state[1:0]}; any write is EOI
//   3 SRC     R   src_req as seen by the edge detector
//
// Build option
//   IRQ_CTRL_SYNC_EN  adds a 2-flop synchronizer on each src_req line
//                     (pending latency +2 cycles, SRC reads synchronized value).

// Per-source lane: optional synchronizer, edge detect, pending bit.
module irq_ctrl_lane (
  input  logic clk,
  input  logic rst,
  input  logic src,       // raw request line
  input  logic clr,       // W1C or ack clear for this source
  output logic src_seen,  // value used by the edge detector
  output logic pend,      // registered pending
  output logic pend_n     // pending value after this edge
);
  logic src_prev;

`ifdef IRQ_CTRL_SYNC_EN
  logic sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end
  assign src_seen = sync2;
`else
  assign src_seen = src;
`endif

  // A fresh edge outranks a clear landing on the same edge, so the
  // request is never lost.
  assign pend_n = (pend & ~clr) | (src_seen & ~src_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev <= 1'b0;
      pend     <= 1'b0;
    end else begin
      src_prev <= src_seen;
      pend     <= pend_n;
    end
  end
endmodule

module irq_ctrl #(
  parameter int NSRC = 4,
  parameter int VECW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            we,
  input  logic            re,
  input  logic [1:0]      addr,
  input  logic [15:0]     wdata,
  output logic [15:0]     rdata,
  output logic            rdy,
  input  logic [NSRC-1:0] src_req,
  output logic            irq,
  output logic [VECW-1:0] irq_vec,
  input  logic            irq_ack
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [NSRC-1:0] enable, enable_n;
  logic [NSRC-1:0] pending, pending_n;
  logic [NSRC-1:0] src_seen;
  logic [NSRC-1:0] clr;
  logic [VECW-1:0] vec_n, winner;
  logic            any_elig;
  logic            wr_en, wr_pend, wr_eoi, ack_take;

  assign wr_en    = sel & we & (addr == 2'd0);
  assign wr_pend  = sel & we & (addr == 2'd1);
  assign wr_eoi   = sel & we & (addr == 2'd2);
  assign ack_take = (state == REQ) & irq_ack;
  assign enable_n = wr_en ? wdata[NSRC-1:0] : enable;

  always_comb begin
    clr = wr_pend ? wdata[NSRC-1:0] : '0;
    if (ack_take) clr[irq_vec] = 1'b1;
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    irq_ctrl_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .src      (src_req[i]),
      .clr      (clr[i]),
      .src_seen (src_seen[i]),
      .pend     (pending[i]),
      .pend_n   (pending_n[i])
    );
  end

  // Fixed priority: scan downward so the lowest eligible index wins.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i] & enable[i]) begin
        winner   = VECW'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = irq_vec;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_n = REQ;
          vec_n   = winner;
        end
      end
      REQ: begin
        // Ack beats withdraw. Withdraw looks at post-edge pending/enable so
        // irq drops on the same edge as the W1C or mask write.
        if (irq_ack)
          state_n = SERVICE;
        else if (!(pending_n[irq_vec] & enable_n[irq_vec]))
          state_n = IDLE;
      end
      SERVICE: begin
        if (wr_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq_vec <= '0;
      enable  <= '0;
    end else begin
      state   <= state_n;
      irq_vec <= vec_n;
      enable  <= enable_n;
    end
  end

  // Decoded from the state register so reset drops it asynchronously.
  assign irq = (state == REQ);
  assign rdy = sel;

  always_comb begin
    rdata = '0;
    if (sel && re) begin
      case (addr)
        2'd0: rdata[NSRC-1:0] = enable;
        2'd1: rdata[NSRC-1:0] = pending;
        2'd2: rdata = {8'b0, 6'(irq_vec), state};
        default: rdata[NSRC-1:0] = src_seen;
      endcase
    end
  end

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata};
endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel, we, re;
  logic [1:0]  addr;
  logic [15:0] wdata, rdata;
  logic        rdy;
  logic [3:0]  src_req;
  logic        irq;
  logic [1:0]  irq_vec;
  logic        irq_ack;

  int total = 0;
  int bad   = 0;

`ifdef IRQ_CTRL_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 4;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 2;
`endif

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(4), .VECW(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdy(rdy), .src_req(src_req),
    .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (spec rules, plain integers) -------------
  bit [3:0] m_en, m_pend, m_prev, m_s1, m_s2;
  int       m_mode;  // 0 idle, 1 presenting, 2 servicing
  int       m_vec;

  function automatic void model_reset();
    m_en = 0; m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
    m_mode = 0; m_vec = 0;
  endfunction

  function automatic bit [15:0] model_read(bit s, bit r, bit [1:0] a, bit [3:0] src);
    if (!(s && r)) return 16'h0;
    case (a)
      2'd0: return {12'h0, m_en};
      2'd1: return {12'h0, m_pend};
      2'd2: return 16'(m_vec * 4 + m_mode);
      default: return {12'h0, (SYNC ? m_s2 : src)};
    endcase
  endfunction

  function automatic void model_step(bit [3:0] src, bit s, bit w, bit [1:0] a,
                                     bit [15:0] d, bit ack);
    bit [3:0] seen, pn, en_n;
    int win;
    seen = SYNC ? m_s2 : src;
    pn   = m_pend;
    if (s && w && a == 2'd1) pn = pn & ~d[3:0];
    if (m_mode == 1 && ack) pn[m_vec] = 1'b0;
    pn   = pn | (seen & ~m_prev);
    en_n = (s && w && a == 2'd0) ? d[3:0] : m_en;
    if (m_mode == 0) begin
      win = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
      if (win >= 0) begin m_mode = 1; m_vec = win; end
    end else if (m_mode == 1) begin
      if (ack) m_mode = 2;
      else if (!(pn[m_vec] && en_n[m_vec])) m_mode = 0;
    end else begin
      if (s && w && a == 2'd2) m_mode = 0;
    end
    m_prev = seen; m_s2 = m_s1; m_s1 = src; m_pend = pn; m_en = en_n;
  endfunction

  // ---------------- scoreboard ------------------------------------------------
  typedef struct {
    bit        irq;
    bit [1:0]  vec;
    bit        rdy;
    bit [15:0] rd;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("sb_irq", int'(irq), int'(e.irq));
      check("sb_vec", int'(irq_vec), int'(e.vec));
      check("sb_rdy", int'(rdy), int'(e.rdy));
      check("sb_rdata", int'(rdata), int'(e.rd));
    end
  end

  // One bus/source cycle: drive, record expectation, advance model, clock.
  task automatic cyc(input bit [3:0] s, input bit sl, input bit w, input bit r,
                     input bit [1:0] a, input bit [15:0] d, input bit ak);
    exp_t e;
    src_req = s; sel = sl; we = w; re = r; addr = a; wdata = d; irq_ack = ak;
    e.irq = (m_mode == 1);
    e.vec = 2'(m_vec);
    e.rdy = sl;
    e.rd  = model_read(sl, r, a, s);
    q.push_back(e);
    model_step(s, sl, w, a, d, ak);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit [3:0] s);
    cyc(s, 0, 0, 0, 2'd0, 16'h0, 0);
  endtask

  task automatic wait_irq(input bit [3:0] s, output int n);
    n = 0;
    while (!irq && n < 20) begin idle(s); n++; end
    if (!irq) check("irq_timeout", 0, 1);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    src_req = 0; sel = 0; we = 0; re = 0; addr = 0; wdata = 0; irq_ack = 0;
    q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit [3:0] s;
    bit sl, w, r, ak;
    bit [1:0] a;
    bit [15:0] d;

    rst = 1'b1;
    src_req = 0; sel = 0; we = 0; re = 0; addr = 0; wdata = 0; irq_ack = 0;
    model_reset();
    #1;
    check("rst_irq", int'(irq), 0);
    check("rst_vec", int'(irq_vec), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while presenting: irq and registers clear with no clock edge.
    cyc(4'h0, 1, 1, 0, 2'd0, 16'h000F, 0);
    cyc(4'h1, 0, 0, 0, 2'd0, 16'h0, 0);
    wait_irq(4'h1, n);
    check("t1_in_req", int'(irq), 1);
    #2 rst = 1'b1;
    #1 check("t1_irq_async", int'(irq), 0);
    sel = 1; re = 1;
    for (int k = 0; k < 3; k++) begin
      addr = 2'(k);
      #1 check("t1_reg_zero", int'(rdata), 0);
    end
    q.delete();
    model_reset();
    sel = 0; re = 0; src_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single source, latency, ack, EOI.
    hard_reset();
    cyc(4'h0, 1, 1, 0, 2'd0, 16'h000F, 0);
    cyc(4'h4, 0, 0, 0, 2'd0, 16'h0, 0);
    n = 1;
    while (!irq && n < 10) begin idle(4'h4); n++; end
    check("t2_latency", n, LAT);
    check("t2_vec", int'(irq_vec), 2);
    cyc(4'h4, 1, 0, 1, 2'd1, 16'h0, 0);
    cyc(4'h4, 0, 0, 0, 2'd0, 16'h0, 1);
    check("t2_irq_after_ack", int'(irq), 0);
    cyc(4'h4, 1, 0, 1, 2'd1, 16'h0, 0);
    check("t2_pend_cleared", int'(rdata), 0);
    cyc(4'h4, 1, 0, 1, 2'd2, 16'h0, 0);
    check("t2_status_svc", int'(rdata), 16'h000A);
    cyc(4'h4, 1, 1, 0, 2'd2, 16'h0, 0);
    cyc(4'h4, 1, 0, 1, 2'd2, 16'h0, 0);
    check("t2_status_idle", int'(rdata[1:0]), 0);
    idle(4'h4); idle(4'h4);
    check("t2_no_reissue", int'(irq), 0);

    // Two simultaneous edges: 0 first, then 3 right after EOI.
    hard_reset();
    cyc(4'h0, 1, 1, 0, 2'd0, 16'h000F, 0);
    cyc(4'h9, 0, 0, 0, 2'd0, 16'h0, 0);
    wait_irq(4'h9, n);
    check("t3_first_vec", int'(irq_vec), 0);
    cyc(4'h9, 0, 0, 0, 2'd0, 16'h0, 1);
    idle(4'h9);
    check("t3_hold_in_svc", int'(irq), 0);
    cyc(4'h9, 1, 1, 0, 2'd2, 16'h0, 0);
    check("t3_eoi_idle", int'(irq), 0);
    idle(4'h9);
    check("t3_second_irq", int'(irq), 1);
    check("t3_second_vec", int'(irq_vec), 3);

    // Masked source latches pending; enabling it raises irq next cycle.
    hard_reset();
    cyc(4'h2, 0, 0, 0, 2'd0, 16'h0, 0);
    idle(4'h2); idle(4'h2); idle(4'h2);
    check("t4_masked_no_irq", int'(irq), 0);
    cyc(4'h2, 1, 0, 1, 2'd1, 16'h0, 0);
    check("t4_pending", int'(rdata), 2);
    cyc(4'h2, 1, 1, 0, 2'd0, 16'h0002, 0);
    check("t4_not_yet", int'(irq), 0);
    idle(4'h2);
    check("t4_irq", int'(irq), 1);
    check("t4_vec", int'(irq_vec), 1);

    // W1C withdraws the request; W1C together with ack still services.
    cyc(4'h2, 1, 1, 0, 2'd1, 16'h0002, 0);
    check("t5_withdraw", int'(irq), 0);
    cyc(4'h2, 1, 0, 1, 2'd2, 16'h0, 0);
    check("t5_state_idle", int'(rdata[1:0]), 0);
    idle(4'h0); idle(4'h0);
    cyc(4'h2, 0, 0, 0, 2'd0, 16'h0, 0);
    wait_irq(4'h2, n);
    cyc(4'h2, 1, 1, 0, 2'd1, 16'h0002, 1);
    check("t5_ack_wins_irq", int'(irq), 0);
    cyc(4'h2, 1, 0, 1, 2'd2, 16'h0, 0);
    check("t5_ack_wins_state", int'(rdata), 16'h0006);

    // Random traffic against the model.
    hard_reset();
    s = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) s[i] = ~s[i];
      sl = ($urandom_range(9) < 3);
      w  = 1'($urandom_range(1));
      r  = 1'($urandom_range(1));
      a  = 2'($urandom_range(3));
      d  = 16'($urandom);
      ak = (m_mode == 1) ? ($urandom_range(9) < 4) : ($urandom_range(19) == 0);
      cyc(s, sl, w, r, a, d, ak);
    end
    idle(s);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
